// File: rtl/parity_frame_checker_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared types and constants for the serial parity frame checker.
//   state_t  : frame FSM states (IDLE -> DATA -> PARITY -> IDLE)
//   PAR_EVEN : odd_mode value selecting even parity
//   PAR_ODD  : odd_mode value selecting odd parity
// ---------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_checker_if.sv
// ---------------------------------------------------------------------------
// parity_frame_checker_if
// Serial-bit input and word-level result bundle of the parity frame checker.
//   bit_in, bit_valid, sof, odd_mode, clr_cnt : driven by the link side
//   data_out, frame_done, parity_err, err_count : driven by the checker
// Modports: master = link side / stimulus, slave = checker.
// ---------------------------------------------------------------------------
interface parity_frame_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              bit_in;
  logic              bit_valid;
  logic              sof;
  logic              odd_mode;
  logic              clr_cnt;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_err;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_in, bit_valid, sof, odd_mode, clr_cnt,
    input  data_out, frame_done, parity_err, err_count
  );

  modport slave (
    input  bit_in, bit_valid, sof, odd_mode, clr_cnt,
    output data_out, frame_done, parity_err, err_count
  );

endinterface

// File: rtl/parity_frame_checker_accum.sv
// ---------------------------------------------------------------------------
// parity_accum
// 1-bit serial XOR accumulator.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : replace the accumulator with i_bit (first bit of a frame)
//   i_en     : XOR i_bit into the accumulator
//   i_bit    : serial bit
//   o_acc    : running XOR of the bits seen since the last load
// i_load wins over i_en.
// ---------------------------------------------------------------------------
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_bit;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_bit;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
// Deserialises DATA_W data bits (LSB first) plus one parity bit per frame and
// checks even/odd parity chosen at start of frame.
//   clk, rst : clock, synchronous active-high reset
//   bus      : parity_frame_checker_if.slave
//     in  : bit_in, bit_valid, sof, odd_mode, clr_cnt
//     out : data_out (last word), frame_done (1-cycle pulse),
//           parity_err (held per frame), err_count (saturating)
// ---------------------------------------------------------------------------
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_frame_checker_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_mode;
  logic [DATA_W-1:0] r_data_out;
  logic              r_frame_done;
  logic              r_parity_err;
  logic [CNT_W-1:0]  r_err_count;

  logic w_load;
  logic w_en;
  logic w_done;
  logic w_acc;
  logic w_err;

  parity_accum u_accum (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_en),
    .i_bit  (bus.bit_in),
    .o_acc  (w_acc)
  );

  // The accumulator holds the XOR of all data bits; folding in the parity bit
  // and the latched mode gives 1 exactly when the frame fails its check.
  assign w_err = w_acc ^ bus.bit_in ^ r_mode;

  // A valid sof restarts a frame from any state, which also covers aborts.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_done       = 1'b0;
    if (bus.bit_valid) begin
      if (bus.sof) begin
        w_load       = 1'b1;
        w_state_next = DATA;
      end else begin
        case (r_state)
          DATA: begin
            w_en = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_state_next = PARITY;
            end
          end
          PARITY: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end
          default: begin
            w_state_next = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_mode       <= PAR_EVEN;
      r_data_out   <= '0;
      r_frame_done <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_done;

      if (w_load) begin
        r_shift <= {{(DATA_W-1){1'b0}}, bus.bit_in};
        r_idx   <= IDX_W'(1);
        r_mode  <= bus.odd_mode;
      end else if (w_en) begin
        r_shift[r_idx] <= bus.bit_in;
        r_idx          <= r_idx + 1'b1;
      end

      if (w_done) begin
        r_data_out   <= r_shift;
        r_parity_err <= w_err;
      end

      // Clear beats a same-cycle increment.
      if (bus.clr_cnt) begin
        r_err_count <= '0;
      end else if (w_done && w_err && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.frame_done = r_frame_done;
  assign bus.parity_err = r_parity_err;
  assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
// Directed bench: two checkers (CNT_W=8 and CNT_W=2) share identical stimulus.
// Inputs change on the falling edge; outputs are read on the falling edge.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;
  import parity_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_W(8), .CNT_W(8)) if8 ();
  parity_frame_checker_if #(.DATA_W(8), .CNT_W(2)) if2 ();

  parity_frame_checker #(.DATA_W(8), .CNT_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  parity_frame_checker #(.DATA_W(8), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_data[$];
  logic       q_err[$];

  // Records every frame_done pulse of the 8-bit-counter instance.
  always @(negedge clk) begin
    if (if8.frame_done === 1'b1) begin
      q_data.push_back(if8.data_out);
      q_err.push_back(if8.parity_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic s, input logic odd, input logic clr);
    @(negedge clk);
    if8.bit_valid = v; if8.bit_in = b; if8.sof = s; if8.odd_mode = odd; if8.clr_cnt = clr;
    if2.bit_valid = v; if2.bit_in = b; if2.sof = s; if2.odd_mode = odd; if2.clr_cnt = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // odd_mode is only correct on the sof bit; it is inverted afterwards so a
  // checker that does not latch the mode gets the wrong answer.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic odd,
                            input int max_gap, input logic clr_on_par);
    int g;
    $display("frame: data=0x%02h parity=%0b odd=%0b max_gap=%0d clr=%0b", d, p, odd, max_gap, clr_on_par);
    for (int i = 0; i < 8; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (i > 0) idle(g);
      drive(1'b1, d[i], (i == 0), (i == 0) ? odd : ~odd, 1'b0);
    end
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    idle(g);
    drive(1'b1, p, 1'b0, ~odd, clr_on_par);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic e);
    if (q_data.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_data"}, q_data.pop_front(), d);
      check({tag, "_err"}, q_err.pop_front(), e);
    end
  endtask

  initial begin
    rst = 1'b1;
    if8.bit_valid = 0; if8.bit_in = 0; if8.sof = 0; if8.odd_mode = 0; if8.clr_cnt = 0;
    if2.bit_valid = 0; if2.bit_in = 0; if2.sof = 0; if2.odd_mode = 0; if2.clr_cnt = 0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_data", if8.data_out, 8'h00);
    check("rst_done", if8.frame_done, 1'b0);
    check("rst_err", if8.parity_err, 1'b0);
    check("rst_cnt8", if8.err_count, 8'd0);
    check("rst_cnt2", if2.err_count, 2'd0);

    // Valid bits without sof in IDLE are ignored.
    repeat (9) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("idle_ignore", q_data.size(), 0);

    send_frame(8'hA5, 1'b0, PAR_EVEN, 0, 1'b0); idle(2);
    expect_frame("even_good", 8'hA5, 1'b0);
    check("even_good_cnt", if8.err_count, 8'd0);

    send_frame(8'hA5, 1'b1, PAR_EVEN, 0, 1'b0); idle(2);
    expect_frame("even_bad", 8'hA5, 1'b1);
    check("even_bad_cnt8", if8.err_count, 8'd1);
    check("even_bad_cnt2", if2.err_count, 2'd1);

    send_frame(8'hA5, 1'b1, PAR_ODD, 0, 1'b0); idle(2);
    expect_frame("odd_good", 8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0, PAR_ODD, 0, 1'b0); idle(2);
    expect_frame("odd_bad", 8'hA5, 1'b1);
    idle(3);
    check("err_held", if8.parity_err, 1'b1);
    check("odd_bad_cnt8", if8.err_count, 8'd2);

    send_frame(8'h3C, 1'b0, PAR_EVEN, 3, 1'b0); idle(2);
    expect_frame("gap_even", 8'h3C, 1'b0);
    send_frame(8'h81, 1'b1, PAR_ODD, 3, 1'b0); idle(2);
    expect_frame("gap_odd", 8'h81, 1'b0);

    send_frame(8'h00, 1'b0, PAR_EVEN, 0, 1'b0);
    send_frame(8'hFF, 1'b0, PAR_EVEN, 0, 1'b0);
    idle(2);
    check("b2b_count", q_data.size(), 2);
    expect_frame("b2b_first", 8'h00, 1'b0);
    expect_frame("b2b_second", 8'hFF, 1'b0);
    check("b2b_data_out", if8.data_out, 8'hFF);

    // Abort from DATA after 5 bits, then from PARITY after all 8 data bits.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, (i == 0), 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, PAR_EVEN, 0, 1'b0); idle(2);
    check("abort_data_count", q_data.size(), 1);
    expect_frame("abort_data", 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0), (i == 0), 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, PAR_EVEN, 0, 1'b0); idle(2);
    check("abort_par_count", q_data.size(), 1);
    expect_frame("abort_par", 8'h0F, 1'b0);
    check("abort_cnt8", if8.err_count, 8'd2);
    check("abort_cnt2", if2.err_count, 2'd2);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(1);
    check("clr_cnt8", if8.err_count, 8'd0);
    check("clr_cnt2", if2.err_count, 2'd0);

    for (int k = 1; k <= 5; k++) begin
      send_frame(8'hA5, 1'b1, PAR_EVEN, 0, 1'b0); idle(2);
      expect_frame($sformatf("sat_%0d", k), 8'hA5, 1'b1);
      check($sformatf("sat_cnt8_%0d", k), if8.err_count, k);
      check($sformatf("sat_cnt2_%0d", k), if2.err_count, (k > 3) ? 3 : k);
    end

    send_frame(8'hA5, 1'b1, PAR_EVEN, 0, 1'b1); idle(2);
    expect_frame("clr_same", 8'hA5, 1'b1);
    check("clr_same_cnt8", if8.err_count, 8'd0);
    check("clr_same_cnt2", if2.err_count, 2'd0);

    send_frame(8'hA5, 1'b1, PAR_EVEN, 0, 1'b0); idle(2);
    expect_frame("pre_rst", 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, (i == 0), 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mrst_data", if8.data_out, 8'h00);
    check("mrst_done", if8.frame_done, 1'b0);
    check("mrst_err", if8.parity_err, 1'b0);
    check("mrst_cnt8", if8.err_count, 8'd0);
    check("mrst_cnt2", if2.err_count, 2'd0);
    // Remaining bits of the discarded frame must not complete anything.
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("mrst_idle", q_data.size(), 0);
    send_frame(8'h5A, 1'b0, PAR_EVEN, 0, 1'b0); idle(2);
    expect_frame("post_rst", 8'h5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
